uart_cmd_ctrl: RTL and testbench

Command controller sitting behind `async_receiver` and in front of `async_transmitter` in the DE0-Nano host link. Frames received bytes into fixed-format register commands (sync, cmd, addr, [data], checksum) and issues single-cycle register write/read strobes to the on-FPGA register bank. Returns one response byte per command (ACK, read data or NAK) through the transmitter's start/busy handshake.

---
 rtl/uart_cmd_ctrl_if.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Host-link command port bundle: received bytes in, response byte handshake out,
// and the register-bank strobes; master is the controller, slave is its surroundings.
interface uart_cmd_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_data_ready;
   logic       rx_endofpacket;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] reg_addr;
   logic [7:0] reg_wr_data;
   logic       reg_wr_en;
   logic       reg_rd_en;
   logic [7:0] reg_rd_data;
   logic       reg_rd_valid;
   logic [7:0] err_count;

   modport master (
      input  rx_data, rx_data_ready, rx_endofpacket, tx_busy, reg_rd_data, reg_rd_valid,
      output tx_start, tx_data, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, err_count
   );

   modport slave (
      output rx_data, rx_data_ready, rx_endofpacket, tx_busy, reg_rd_data, reg_rd_valid,
      input  tx_start, tx_data, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, err_count
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames UART bytes into register write/read commands; strobes 1 cycle after the csum byte,
// one response byte per command, held in RESP until tx_busy drops; bytes arriving mid-command are dropped.
module uart_cmd_ctrl #(
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter logic [7:0]  ACK_BYTE   = 8'h5A,
   parameter logic [7:0]  NAK_BYTE   = 8'hEE,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst_n,
   uart_cmd_ctrl_if.master bus
);
   localparam logic [7:0]  CMD_WR   = 8'h01;
   localparam logic [7:0]  CMD_RD   = 8'h02;
   localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CSUM, EXEC, RD_WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic        is_wr, is_wr_nxt;
   logic [7:0]  addr_q, addr_nxt;
   logic [7:0]  data_q, data_nxt;
   logic [7:0]  resp_q, resp_nxt;
   logic [7:0]  tx_data_q, tx_data_nxt;
   logic [7:0]  err_q, err_nxt;
   logic [15:0] timer_q, timer_nxt;
   logic        wr_en_q, wr_en_nxt;
   logic        rd_en_q, rd_en_nxt;
   logic        tx_start_q, tx_start_nxt;
   logic        err_hit;
   logic [7:0]  csum_exp;

   assign csum_exp = is_wr ? (CMD_WR ^ addr_q ^ data_q) : (CMD_RD ^ addr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_wr      <= 1'b0;
         addr_q     <= 8'h00;
         data_q     <= 8'h00;
         resp_q     <= 8'h00;
         tx_data_q  <= 8'h00;
         err_q      <= 8'h00;
         timer_q    <= 16'h0000;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_start_q <= 1'b0;
      end else begin
         is_wr      <= is_wr_nxt;
         addr_q     <= addr_nxt;
         data_q     <= data_nxt;
         resp_q     <= resp_nxt;
         tx_data_q  <= tx_data_nxt;
         err_q      <= err_nxt;
         timer_q    <= timer_nxt;
         wr_en_q    <= wr_en_nxt;
         rd_en_q    <= rd_en_nxt;
         tx_start_q <= tx_start_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      is_wr_nxt    = is_wr;
      addr_nxt     = addr_q;
      data_nxt     = data_q;
      resp_nxt     = resp_q;
      tx_data_nxt  = tx_data_q;
      err_nxt      = err_q;
      timer_nxt    = timer_q;
      wr_en_nxt    = 1'b0;
      rd_en_nxt    = 1'b0;
      tx_start_nxt = 1'b0;
      err_hit      = 1'b0;

      // A byte in the same cycle as end-of-packet is consumed and the abort is ignored.
      case (state)
         IDLE: begin
            if (bus.rx_data_ready && bus.rx_data == SYNC_BYTE) state_nxt = CMD;
         end
         CMD: begin
            if (bus.rx_data_ready) begin
               if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                  is_wr_nxt = (bus.rx_data == CMD_WR);
                  state_nxt = ADDR;
               end else begin
                  err_hit = 1'b1;
               end
            end else if (bus.rx_endofpacket) begin
               err_hit = 1'b1;
            end
         end
         ADDR: begin
            if (bus.rx_data_ready) begin
               addr_nxt  = bus.rx_data;
               state_nxt = is_wr ? DATA : CSUM;
            end else if (bus.rx_endofpacket) begin
               err_hit = 1'b1;
            end
         end
         DATA: begin
            if (bus.rx_data_ready) begin
               data_nxt  = bus.rx_data;
               state_nxt = CSUM;
            end else if (bus.rx_endofpacket) begin
               err_hit = 1'b1;
            end
         end
         CSUM: begin
            if (bus.rx_data_ready) begin
               if (bus.rx_data == csum_exp) begin
                  wr_en_nxt = is_wr;
                  rd_en_nxt = !is_wr;
                  state_nxt = EXEC;
               end else begin
                  err_hit = 1'b1;
               end
            end
         end
         EXEC: begin
            if (is_wr) begin
               resp_nxt  = ACK_BYTE;
               state_nxt = RESP;
            end else begin
               timer_nxt = 16'h0000;
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // timer_q counts from 0 on the first cycle after the read strobe.
            if (bus.reg_rd_valid) begin
               resp_nxt  = bus.reg_rd_data;
               state_nxt = RESP;
            end else if (timer_q == TMO_LAST) begin
               err_hit = 1'b1;
            end else begin
               timer_nxt = timer_q + 16'h0001;
            end
         end
         RESP: begin
            if (!bus.tx_busy) begin
               tx_start_nxt = 1'b1;
               tx_data_nxt  = resp_q;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (err_hit) begin
         resp_nxt  = NAK_BYTE;
         state_nxt = RESP;
         if (err_q != 8'hFF) err_nxt = err_q + 8'h01;
      end
   end

   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.reg_addr    = addr_q;
   assign bus.reg_wr_data = data_q;
   assign bus.reg_wr_en   = wr_en_q;
   assign bus.reg_rd_en   = rd_en_q;
   assign bus.err_count   = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed and randomized bench for uart_cmd_ctrl against a packet-level reference model.
module tb_uart_cmd_ctrl;
   localparam int         T    = 16;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [7:0] ACK  = 8'h5A;
   localparam logic [7:0] NAK  = 8'hEE;
   typedef logic [7:0] bq_t [$];

   logic clk;
   logic rst_n;
   uart_cmd_ctrl_if bus ();
   uart_cmd_ctrl #(.RD_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int cyc = 0;
   int n_tx = 0, n_wr = 0, n_rd = 0;
   int tx_cyc = 0, wr_cyc = 0, rd_cyc = 0, rx_cyc = 0;
   logic [7:0] tx_last = 0, wr_addr = 0, wr_dat = 0;
   int rd_lat = -1;
   logic [7:0] rd_val = 0;
   bit rd_pend = 0;
   int rd_due = 0;
   int n_assert = 0, n_fail = 0, exp_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder and read-data responder, both on the falling edge.
   initial begin
      bus.reg_rd_valid = 1'b0;
      bus.reg_rd_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.tx_start)  begin n_tx++; tx_cyc = cyc; tx_last = bus.tx_data; end
         if (bus.reg_wr_en) begin n_wr++; wr_cyc = cyc; wr_addr = bus.reg_addr; wr_dat = bus.reg_wr_data; end
         if (bus.reg_rd_en) begin n_rd++; rd_cyc = cyc; rd_pend = (rd_lat >= 0); rd_due = cyc + rd_lat; end
         if (bus.rx_data_ready) rx_cyc = cyc;
         bus.reg_rd_valid = rd_pend && (cyc == rd_due);
         bus.reg_rd_data  = bus.reg_rd_valid ? rd_val : ~rd_val;
         if (bus.reg_rd_valid) rd_pend = 0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [34:0] outs();
      return {bus.tx_start, bus.tx_data, bus.reg_addr, bus.reg_wr_data,
              bus.reg_wr_en, bus.reg_rd_en, bus.err_count};
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit eop);
      @(posedge clk); #1;
      bus.rx_data = b; bus.rx_data_ready = 1'b1; bus.rx_endofpacket = eop;
      @(posedge clk); #1;
      bus.rx_data_ready = 1'b0; bus.rx_endofpacket = 1'b0;
   endtask

   task automatic send_pkt(input bq_t p);
      foreach (p[k]) send_byte(p[k], 1'b0);
   endtask

   task automatic send_eop();
      @(posedge clk); #1; bus.rx_endofpacket = 1'b1;
      @(posedge clk); #1; bus.rx_endofpacket = 1'b0;
   endtask

   task automatic wait_tx(input int n0, input string tag);
      int k = 0;
      while (n_tx == n0 && k < 300) begin @(posedge clk); #1; k++; end
      check({tag, "_tx_count"}, n_tx, n0 + 1);
   endtask

   // Expected outcome of one packet, from the framing/checksum/timeout rules.
   task automatic model(input bq_t p, input bit trunc, input int lat, input logic [7:0] rv,
                        output logic [7:0] resp, output bit nak, output bit wr, output bit rd);
      logic [7:0] x;
      int len;
      resp = NAK; nak = 1; wr = 0; rd = 0;
      if (trunc || p.size() < 2) return;
      if (p[1] != 8'h01 && p[1] != 8'h02) return;
      len = (p[1] == 8'h01) ? 5 : 4;
      x = 8'h00;
      for (int k = 1; k < len - 1; k++) x ^= p[k];
      if (p[len-1] !== x) return;
      if (p[1] == 8'h01) begin wr = 1; nak = 0; resp = ACK; end
      else begin
         rd = 1;
         if (lat >= 1 && lat <= T) begin nak = 0; resp = rv; end
      end
   endtask

   bq_t pkt, full;
   int n0, w0, r0, low_cyc, kind, lat, ng, hold, len_max;
   logic [7:0] a, d, cmd, g, m_resp;
   bit trunc, m_nak, m_wr, m_rd;

   initial begin
      rst_n = 1'b0;
      bus.rx_data = 8'h00; bus.rx_data_ready = 1'b0; bus.rx_endofpacket = 1'b0; bus.tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs(), 35'h0);
      rst_n = 1'b1;

      // Good write
      n0 = n_tx; w0 = n_wr;
      pkt = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
      send_pkt(pkt);
      wait_tx(n0, "wr");
      check("wr_strobes", n_wr - w0, 1);
      check("wr_addr", wr_addr, 8'h10);
      check("wr_data", wr_dat, 8'h3C);
      check("wr_strobe_lat", wr_cyc - rx_cyc, 1);
      check("wr_resp", tx_last, ACK);
      check("wr_tx_lat", tx_cyc - rx_cyc, 3);
      check("wr_err", bus.err_count, 0);

      // Read, data 3 cycles after strobe
      n0 = n_tx; w0 = n_wr; r0 = n_rd; rd_lat = 3; rd_val = 8'h99;
      pkt = '{8'hA5, 8'h02, 8'h20, 8'h22};
      send_pkt(pkt);
      wait_tx(n0, "rd3");
      check("rd3_resp", tx_last, 8'h99);
      check("rd3_strobes", n_rd - r0, 1);
      check("rd3_no_wr", n_wr - w0, 0);
      check("rd3_strobe_lat", rd_cyc - rx_cyc, 1);
      check("rd3_tx_lat", tx_cyc - rd_cyc, 5);
      repeat (3) @(posedge clk);
      #1;

      // Read, never valid: timeout
      n0 = n_tx; rd_lat = -1;
      send_pkt(pkt);
      wait_tx(n0, "rdto");
      exp_err++;
      check("rdto_resp", tx_last, NAK);
      check("rdto_tx_lat", tx_cyc - rd_cyc, T + 2);
      check("rdto_err", bus.err_count, exp_err);

      // Valid exactly on the timeout cycle wins
      n0 = n_tx; rd_lat = T; rd_val = 8'h42;
      send_pkt(pkt);
      wait_tx(n0, "rdlast");
      check("rdlast_resp", tx_last, 8'h42);
      check("rdlast_err", bus.err_count, exp_err);

      // Valid in the same cycle as the strobe is ignored
      n0 = n_tx; rd_lat = 0; rd_val = 8'h17;
      send_pkt(pkt);
      wait_tx(n0, "rd0");
      exp_err++;
      check("rd0_resp", tx_last, NAK);
      check("rd0_err", bus.err_count, exp_err);

      // Bad checksum
      n0 = n_tx; w0 = n_wr; r0 = n_rd;
      pkt = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00};
      send_pkt(pkt);
      wait_tx(n0, "csum");
      exp_err++;
      check("csum_no_strobe", (n_wr - w0) + (n_rd - r0), 0);
      check("csum_resp", tx_last, NAK);
      check("csum_tx_lat", tx_cyc - rx_cyc, 2);
      check("csum_err", bus.err_count, exp_err);

      // Unknown command; a full write sent during the response wait must be dropped
      n0 = n_tx; w0 = n_wr; bus.tx_busy = 1'b1;
      pkt = '{8'hA5, 8'h07};
      send_pkt(pkt);
      pkt = '{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
      send_pkt(pkt);
      bus.tx_busy = 1'b0;
      wait_tx(n0, "ucmd");
      exp_err++;
      check("ucmd_resp", tx_last, NAK);
      repeat (10) @(posedge clk);
      #1;
      check("ucmd_dropped_wr", n_wr - w0, 0);
      check("ucmd_single_tx", n_tx - n0, 1);
      pkt = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D};
      send_pkt(pkt);
      wait_tx(n0 + 1, "garb");
      check("garb_resp", tx_last, ACK);
      check("garb_wr", n_wr - w0, 1);
      check("garb_err", bus.err_count, exp_err);

      // Byte and end-of-packet together: byte wins, packet continues
      n0 = n_tx;
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b0); send_byte(8'h01 ^ 8'h33 ^ 8'h44, 1'b0);
      wait_tx(n0, "eopbyte");
      check("eopbyte_resp", tx_last, ACK);
      check("eopbyte_wr", {wr_addr, wr_dat}, 16'h3344);

      // Abort with transmitter busy for 20 cycles
      n0 = n_tx; bus.tx_busy = 1'b1;
      pkt = '{8'hA5, 8'h01, 8'h10};
      send_pkt(pkt);
      send_eop();
      repeat (20) @(posedge clk);
      #1;
      check("abort_held", n_tx - n0, 0);
      bus.tx_busy = 1'b0; low_cyc = cyc;
      wait_tx(n0, "abort");
      exp_err++;
      check("abort_resp", tx_last, NAK);
      check("abort_tx_lat", tx_cyc - low_cyc, 1);
      check("abort_err", bus.err_count, exp_err);

      // Randomized packets against the reference model
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         a = 8'($urandom); d = 8'($urandom); rd_val = 8'($urandom);
         lat = $urandom_range(0, T + 2);
         if ($urandom_range(0, 7) == 0) lat = -1;
         rd_lat = lat;
         if (kind == 0)      cmd = 8'h01;
         else if (kind == 1) cmd = 8'h02;
         else if (kind == 3) begin
            cmd = 8'($urandom_range(3, 255));
            if ($urandom_range(0, 3) == 0) cmd = 8'h00;
         end
         else cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
         if (cmd == 8'h01) full = '{SYNC, cmd, a, d, cmd ^ a ^ d};
         else              full = '{SYNC, cmd, a, cmd ^ a};
         if (kind == 2) full[full.size()-1] = full[full.size()-1] ^ 8'($urandom_range(1, 255));
         trunc = (kind == 4);
         pkt = full;
         if (kind == 3) pkt = '{SYNC, cmd};
         if (trunc) begin
            len_max = (cmd == 8'h01) ? 3 : 2;
            pkt = full[0:$urandom_range(0, len_max - 1)];
         end
         ng = $urandom_range(0, 2); hold = $urandom_range(0, 3);
         n0 = n_tx; w0 = n_wr; r0 = n_rd;
         bus.tx_busy = (hold > 0);
         for (int k = 0; k < ng; k++) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h00;
            send_byte(g, 1'b0);
         end
         send_pkt(pkt);
         if (trunc) send_eop();
         repeat (hold) @(posedge clk);
         #1;
         bus.tx_busy = 1'b0;
         wait_tx(n0, "rand");
         model(pkt, trunc, lat, rd_val, m_resp, m_nak, m_wr, m_rd);
         if (m_nak && exp_err < 255) exp_err++;
         check("rand_resp", tx_last, m_resp);
         check("rand_wr", n_wr - w0, m_wr);
         check("rand_rd", n_rd - r0, m_rd);
         if (m_wr) check("rand_wr_addr_data", {wr_addr, wr_dat}, {pkt[2], pkt[3]});
         check("rand_err", bus.err_count, exp_err);
         repeat (4) @(posedge clk);
         #1;
      end

      // Saturation of the error counter
      for (int i = 0; i < 260; i++) begin
         n0 = n_tx;
         pkt = '{8'hA5, 8'h07};
         send_pkt(pkt);
         wait_tx(n0, "sat");
         if (exp_err < 255) exp_err++;
      end
      check("sat_err", bus.err_count, 8'hFF);
      check("sat_model", exp_err, 255);

      // Asynchronous reset mid-packet
      pkt = '{8'hA5, 8'h01, 8'h10};
      send_pkt(pkt);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", outs(), 35'h0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 0;

      // Fresh write after reset, then hold of address/data
      n0 = n_tx;
      pkt = '{8'hA5, 8'h01, 8'h44, 8'h55, 8'h10};
      send_pkt(pkt);
      wait_tx(n0, "post");
      check("post_resp", tx_last, ACK);
      check("post_err", bus.err_count, 0);
      repeat (10) @(posedge clk);
      #1;
      check("hold_regs", {bus.reg_addr, bus.reg_wr_data}, 16'h4455);
      n0 = n_tx; rd_lat = 2; rd_val = 8'h5C;
      pkt = '{8'hA5, 8'h02, 8'h77, 8'h75};
      send_pkt(pkt);
      wait_tx(n0, "post_rd");
      check("post_rd_resp", tx_last, 8'h5C);
      check("post_rd_regs", {bus.reg_addr, bus.reg_wr_data}, 16'h7755);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
